// File: rtl/keypad_hex_scanner.sv
// keypad_hex_scanner: 4x4 hex keypad column scanner with debounce, feeding an N-bit digit shift register
module keypad_hex_scanner #(
  parameter int N        = 16,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic [3:0]   rows,
  output logic [3:0]   cols,
  output logic [3:0]   key_code,
  output logic         key_valid,
  output logic         key_held,
  output logic [N-1:0] value
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [1:0] IDLE = 2'd0, CAND = 2'd1, PRESSED = 2'd2, REL = 2'd3;
  // entry i = row*4+col holds that key's hex code
  localparam logic [63:0] KEYMAP = {4'hD, 4'hE, 4'hF, 4'h0, 4'hC, 4'h9, 4'h8, 4'h7,
                                    4'hB, 4'h6, 4'h5, 4'h4, 4'hA, 4'h3, 4'h2, 4'h1};
  logic [3:0]    rs1_q, rs2_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    col_q, col_d, state_q, state_d;
  logic [15:0]   img_q, img_d;
  logic          done_q, done_d, valid_q, valid_d, wrap, accept, none, single;
  logic [3:0]    cand_q, cand_d, code_q, code_d, idx, k;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [N-1:0]  value_q, value_d;
  always_comb begin
    wrap = slot_q == SW'(SCAN_DIV - 1);
    slot_d = wrap ? '0 : slot_q + 1'b1;
    col_d = wrap ? col_q + 2'd1 : col_q;
    img_d = img_q;
    for (int r = 0; r < 4; r++)
      if (wrap) img_d[r*4 + int'(col_q)] = ~rs2_q[r];
    done_d = wrap && col_q == 2'd3;
    idx = '0;
    for (int i = 15; i >= 0; i--)
      if (img_q[i]) idx = 4'(i);
    none = img_q == '0;
    single = $countones(img_q) == 1;
    k = KEYMAP[{idx, 2'b00} +: 4];
    cnt_inc = cnt_q + 1'b1;
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    accept = 1'b0;
    if (done_q)
      case (state_q)
        IDLE: if (single) begin
          cand_d = idx;
          cnt_d = CW'(1);
          accept = DEBOUNCE == 1;
          state_d = DEBOUNCE == 1 ? PRESSED : CAND;
        end
        CAND: if (single && idx == cand_q) begin
          cnt_d = cnt_inc;
          accept = cnt_inc == CW'(DEBOUNCE);
          state_d = accept ? PRESSED : CAND;
        end else if (single) begin
          cand_d = idx;
          cnt_d = CW'(1);
        end else state_d = IDLE;
        PRESSED: if (none) begin
          cnt_d = CW'(1);
          state_d = DEBOUNCE == 1 ? IDLE : REL;
        end
        default: if (none) begin
          cnt_d = cnt_inc;
          state_d = cnt_inc == CW'(DEBOUNCE) ? IDLE : REL;
        end else state_d = PRESSED;
      endcase
    code_d = accept ? k : code_q;
    valid_d = accept;
    value_d = clear ? '0 : value_q;
    value_d = accept ? (value_d << 4) | N'(k) : value_d;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rs1_q   <= 4'hF;
      rs2_q   <= 4'hF;
      slot_q  <= '0;
      col_q   <= '0;
      img_q   <= '0;
      done_q  <= 1'b0;
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      value_q <= '0;
    end else begin
      rs1_q   <= rows;
      rs2_q   <= rs1_q;
      slot_q  <= slot_d;
      col_q   <= col_d;
      img_q   <= img_d;
      done_q  <= done_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      value_q <= value_d;
    end
  end
  assign cols      = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = state_q[1];
  assign value     = value_q;
endmodule

// File: tb/tb_keypad_hex_scanner.sv
// tb_keypad_hex_scanner: scoreboard bench driving a modelled 4x4 keypad into keypad_hex_scanner
module tb_keypad_hex_scanner;
  localparam int SCAN = 16;
  logic        clock = 1'b0, reset, clear;
  logic [3:0]  rows, cols, key_code;
  logic        key_valid, key_held;
  logic [15:0] value, keys, expv;
  logic [19:0] sb_q[$];
  int n_cmp = 0, n_err = 0, n_pulse = 0, pulse_cyc = -1, cyc = 0;
  keypad_hex_scanner #(.N(16), .SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clock(clock), .reset(reset), .clear(clear), .rows(rows), .cols(cols),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .value(value)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clock) begin
    logic [19:0] e;
    check("cols_onecold", 32'($countones(~cols)), 1);
    if (key_valid) begin
      n_pulse++;
      pulse_cyc = cyc;
      if (sb_q.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        e = sb_q.pop_front();
        check("key_code", 32'(key_code), 32'(e[19:16]));
        check("value", 32'(value), 32'(e[15:0]));
      end
    end
  end
  task automatic wait_scans(input int n);
    repeat (n * SCAN) @(negedge clock);
  endtask
  task automatic expect_key(input logic [3:0] k);
    expv = {expv[11:0], k};
    sb_q.push_back({k, expv});
  endtask
  task automatic tap(input int idx, input logic [3:0] k);
    expect_key(k);
    keys[idx] = 1'b1;
    wait_scans(3);
    keys[idx] = 1'b0;
    wait_scans(3);
    check("tap_value", 32'(value), 32'(expv));
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    expv = '0;
    check("clear_value", 32'(value), 0);
  endtask
  task automatic check_reset_state();
    check("rst_cols", 32'(cols), 32'hE);
    check("rst_code", 32'(key_code), 0);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_held", 32'(key_held), 0);
    check("rst_value", 32'(value), 0);
  endtask
  initial begin
    int np;
    reset = 1'b1;
    clear = 1'b0;
    keys = '0;
    expv = '0;
    repeat (3) @(negedge clock);
    check_reset_state();
    keys[5] = 1'b1;
    expect_key(4'h5);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("latency_ok", 32'(pulse_cyc >= 32 && pulse_cyc <= 36), 1);
    check("held_while_pressed", 32'(key_held), 1);
    keys = '0;
    wait_scans(1);
    check("held_after_1_empty", 32'(key_held), 1);
    wait_scans(3);
    check("held_released", 32'(key_held), 0);
    check("drain_single", 32'(sb_q.size()), 0);
    pulse_clear();
    tap(0, 4'h1);
    tap(1, 4'h2);
    tap(2, 4'h3);
    tap(4, 4'h4);
    tap(3, 4'hA);
    check("wrap_value", 32'(value), 32'h234A);
    np = n_pulse;
    repeat (5) begin
      keys[5] = 1'b1;
      wait_scans(1);
      keys[5] = 1'b0;
      wait_scans(1);
    end
    wait_scans(2);
    check("bounce_pulses", 32'(n_pulse - np), 0);
    check("bounce_value", 32'(value), 32'(expv));
    keys[0] = 1'b1;
    keys[11] = 1'b1;
    wait_scans(4);
    check("multi_pulses", 32'(n_pulse - np), 0);
    expect_key(4'h1);
    keys[11] = 1'b0;
    wait_scans(3);
    check("multi_then_single", 32'(n_pulse - np), 1);
    keys = '0;
    wait_scans(3);
    expect_key(4'h7);
    keys[8] = 1'b1;
    wait_scans(3);
    np = n_pulse;
    keys[10] = 1'b1;
    wait_scans(2);
    keys[8] = 1'b0;
    wait_scans(3);
    check("no_second_key", 32'(n_pulse - np), 0);
    check("held_over_swap", 32'(key_held), 1);
    keys = '0;
    wait_scans(3);
    check("no_key_after_release", 32'(n_pulse - np), 0);
    tap(10, 4'h9);
    check("seq_value", 32'(value), 32'hA179);
    pulse_clear();
    tap(4, 4'h4);
    expect_key(4'h8);
    keys[9] = 1'b1;
    wait_scans(3);
    check("before_reset_value", 32'(value), 32'h0048);
    check("drain_pre_reset", 32'(sb_q.size()), 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_state();
    expv = '0;
    expect_key(4'h8);
    wait_scans(3);
    check("reaccept_after_reset", 32'(sb_q.size()), 0);
    keys = '0;
    wait_scans(3);
    for (int i = 0; i < SCAN && cyc % SCAN != 1; i++) @(negedge clock);
    keys[7] = 1'b1;
    expv = '0;
    expect_key(4'hB);
    repeat (31) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    wait_scans(2);
    check("clear_with_accept", 32'(value), 32'h000B);
    keys = '0;
    wait_scans(3);
    check("drain_final", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_hex_scanner.md
# keypad_hex_scanner

Scans a 4x4 hexadecimal matrix keypad and delivers debounced key presses as hex digits, shifting each new digit into an N-bit entry register. It is the input-side counterpart of the multiplexed 7-segment display path. It strobes keypad columns one at a time, much as the display driver strobes anodes, and reads the row lines back. The `value` output is sized to feed the display driver's `BCD_in` directly, so typed digits appear on the displays.

## Interface
- `N`, 16, entry register width in bits; multiple of 4, range 4..32.
- `SCAN_DIV`, 50000, clock cycles each column is held active; minimum 4.
- `DEBOUNCE`, 4, consecutive identical full scans required to accept a press or a release; minimum 1.

- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high; resets all state.
- `clear`  in  1  synchronous, active-high; zeroes `value` only.
- `rows`  in  4  keypad row lines, active-low (pulled up), asynchronous.
- `cols`  out  4  column strobes, one-cold: exactly one bit is low at any time.
- `key_code`  out  4  hex code of the last accepted key.
- `key_valid`  out  1  one-cycle pulse when a press is accepted.
- `key_held`  out  1  high while an accepted key has not yet been released.
- `value`  out  N  entry register: the last N/4 accepted digits, newest in the least-significant nibble.

## Operation
- **Row synchronizer:** `rows` passes through a 2-flop synchronizer. All logic uses only the synchronized copy.
- **Column scan:**
  - A slot counter runs from 0 to SCAN_DIV-1.
  - `cols` cycles 1110 → 1101 → 1011 → 0111 → 1110, advancing when the slot counter wraps.
  - The synchronized rows are sampled in slot cycle SCAN_DIV-1 into a 16-bit scan image, bit index = row*4 + col, with 1 meaning pressed.
- **Scan evaluation:** when column 3 is sampled, the scan is complete. It is evaluated in the next cycle with exactly one of these results:
  - NONE: zero bits set.
  - SINGLE(k): exactly one bit set.
  - MULTI: two or more bits set.
- **Key map** (row, col → code):
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: 0, F, E, D.
- **FSM states:** IDLE, CAND, PRESSED, REL.
  - IDLE: on SINGLE(k), latch candidate k, set count=1, go to CAND. If DEBOUNCE=1, accept immediately instead.
  - CAND:
    - SINGLE of the same k: increment count. When count reaches DEBOUNCE, accept and go to PRESSED.
    - SINGLE of a different key: restart with the new candidate, count=1.
    - NONE or MULTI: return to IDLE.
  - PRESSED: on NONE, set count=1 and go to REL (or straight to IDLE if DEBOUNCE=1). SINGLE and MULTI are both ignored and the FSM stays in PRESSED; no second key is accepted while one is held.
  - REL: NONE increments count, and the FSM goes to IDLE when count reaches DEBOUNCE. Any SINGLE or MULTI returns to PRESSED.
- **Accept action:**
  - `key_code` ← k.
  - `key_valid` = 1 for exactly one cycle.
  - `value` ← {value[N-5:0], k}. The oldest nibble is discarded (shift-in wrap-around).
- **`key_held`:** 1 in the PRESSED and REL states, 0 otherwise.
- **`clear`:** sets `value` to 0 and affects nothing else. If `clear` and an accept occur in the same cycle, `value` becomes {0, k}; `key_code` and `key_valid` behave normally.

## Timing
- **Reset values:**
  - `cols` = 1110.
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0, `value` = 0.
  - FSM in IDLE; slot counter, column index, debounce count and scan image all 0.
- **Reset mid-operation:** reset discards any partial scan and any held key. A key still held after reset is accepted again as a new press after DEBOUNCE full scans.
- **Outputs:** all are registered, with no combinational path from `rows`.
- **Rows settling:** rows must be valid within SCAN_DIV-3 cycles of a column change; this allows for the 2-flop synchronizer latency.
- **Full scan:** one full scan takes 4*SCAN_DIV cycles.
- **Accept latency:** `key_valid` rises 2 cycles after the column-3 sample cycle of the DEBOUNCE-th consecutive matching scan (1 cycle for evaluation, 1 for the registered output). `value` and `key_code` update on that same edge.
- **Press-to-accept:** a press that is stable from a scan boundary is accepted DEBOUNCE*4*SCAN_DIV + 2 cycles later (±2 for synchronizer latency).

## Test plan
Common setup: SCAN_DIV=4, DEBOUNCE=2, N=16. The bench keypad model pulls row r low whenever the active column matches a pressed key.

- Hold key at (1,1) from reset release → exactly one `key_valid` pulse, at cycle 2*16+2 ±2; `key_code`=5, `value`=0x0005, `key_held`=1 until 2 empty scans after release.
- Press and release 1, 2, 3, 4, A in sequence, each held 3 scans with a 3-scan gap → five pulses; `value` reads 0x0001, 0x0012, 0x0123, 0x1234, then 0x234A (wrap-around).
- Bounce case: key held for only 1 scan, then 1 empty scan, repeated 5 times → no `key_valid` pulse and `value` unchanged.
- Press keys (0,0) and (2,3) together for 4 scans → no pulse. Then release (2,3) → after 2 scans, code 1 is accepted.
- While 7 is held (accepted), press 9 as well, then release only 7 → no pulse for 9 until all keys are released for 2 scans and 9 is pressed again.
- Assert `reset` for 1 cycle while 8 is held (`value`=0x0048) → outputs go to their reset values; 8 is accepted again 2 scans later with `value`=0x0008. Separately, `clear` coincident with an accept of B gives `value`=0x000B.
